down_timer: RTL
===============

# down_timer

Loadable down-counting timer: the decrementing counterpart of the team's modulo up-counter. It counts a programmed value down to zero on enabled ticks and flags the underflow one tick ahead. It then either stops or reloads itself for periodic operation. It sits beside the up-counter in timeout, watchdog and rate-divider paths, where a count must be set from a register and run down rather than counted up to a fixed limit.

## Interface
- `Limit`, default 16: number of distinct count values (0 .. Limit-1); must be ≥ 2.
- `Width`, localparam = $clog2(Limit): width of the count value; not overridable.

Ports:
- `clk_i`  input  1: clock; all state updates on the rising edge.
- `rst_ni`  input  1: reset, asynchronous, active-low.
- `load_i`  input  1: load `load_value_i` into count and reload registers; forces IDLE.
- `load_value_i`  input  Width: value to load.
- `start_i`  input  1: IDLE → RUN.
- `stop_i`  input  1: RUN → IDLE; count held.
- `dec_i`  input  1: tick enable; counts only in RUN.
- `auto_reload_i`  input  1: on underflow, 1 = reload and keep running, 0 = stop.
- `value_o`  output  Width: current count (registered).
- `busy_o`  output  1: high while in RUN (registered).
- `will_underflow_o`  output  1: combinational; high when in RUN and `value_o` == 0.
- `expired_o`  output  1: registered one-cycle pulse after each underflow tick.

## Operation
- Registers: `value_q`, `reload_q`, `state_q` (IDLE/RUN) and `expired_q`.
- Reset, asserted asynchronously:
  - `value_q` = 0, `reload_q` = 0, state = IDLE.
  - `expired_o` = 0, `busy_o` = 0, `will_underflow_o` = 0.
- Load clamp: a `load_value_i` ≥ Limit (possible only when Limit is not a power of 2) is stored as Limit-1.
- Per-cycle priority: `load_i` > `stop_i` > `start_i` > `dec_i`. Only the highest-priority active input acts.
- `load_i` (any state):
  - `value_q` and `reload_q` take the clamped value.
  - State goes to IDLE.
  - No expiry, even if the same cycle was an underflow tick.
- `stop_i`:
  - In RUN: go to IDLE with `value_q` unchanged; a coincident `dec_i` is discarded.
  - In IDLE: no-op.
- `start_i`:
  - In IDLE: go to RUN. Starting with `value_q` = 0 is legal; the first tick underflows.
  - In RUN: no-op.
- `dec_i` in RUN:
  - `value_q` ≠ 0: decrement by 1.
  - `value_q` = 0 (underflow tick):
    - `expired_q` is set for one cycle.
    - If `auto_reload_i` = 1, sampled on this cycle: `value_q` ← `reload_q` and stay in RUN.
    - Otherwise: `value_q` stays 0 and state goes to IDLE.
- `dec_i` in IDLE: ignored.
- Auto-reload period: reload value R gives expiry every R+1 ticks. R = 0 gives expiry on every tick.
- Arithmetic: decrement is Width-bit and never wraps. The underflow path is the only transition out of 0, and it goes to `reload_q` or holds.
- `value_o` reads `value_q` directly; `busy_o` = (state == RUN).

## Timing
- All registered outputs change one cycle after the causing input is sampled.
- `will_underflow_o` is valid in the same cycle as the `value_o` it describes. It is high in exactly the cycles where a `dec_i` would cause expiry.
- `expired_o` is high for exactly one cycle: the cycle after the underflow tick. In that cycle:
  - With auto-reload, `value_o` = R.
  - Without auto-reload, `value_o` = 0 and `busy_o` = 0.
- Back-to-back underflows (R = 0, `dec_i` held high) keep `expired_o` high continuously. There is one pulse per tick; this is not a fault.
- Reset asserted mid-RUN clears all state immediately, without a clock. After `rst_ni` deasserts, the first edge sees IDLE, 0.

## Test plan
- Reset mid-run:
  - Stimulus: load 5, start, 2 ticks, then assert `rst_ni` low between edges.
  - Response: `value_o` = 0, `busy_o` = 0 and `expired_o` = 0 immediately; no activity after release.
- One-shot countdown:
  - Stimulus: load 3, start, hold `dec_i` = 1.
  - Response: `value_o` runs 3, 2, 1, 0. `will_underflow_o` is high during the 0 cycle. On the next edge `expired_o` = 1 for one cycle, `busy_o` = 0 and `value_o` stays 0.
- Auto-reload period:
  - Stimulus: load 2, `auto_reload_i` = 1, start, `dec_i` = 1 for 9 cycles.
  - Response: `expired_o` pulses every 3rd cycle (3 pulses); `value_o` shows 2 in each pulse cycle; `busy_o` stays high.
- Priority collisions:
  - Stimulus: in RUN at value 4, assert `stop_i` + `dec_i` together; later assert `load_i` = 7 + `start_i` together.
  - Response: stop leaves 4 in IDLE. The load leaves 7 in IDLE, and `busy_o` stays 0.
- Load clamp and underflow-tick load:
  - Clamp: with Limit = 10, load 12 → `value_o` = 9.
  - Stimulus: run down to 0, then assert `load_i` = 6 together with `dec_i`.
  - Response: no `expired_o` pulse; `value_o` = 6; IDLE.
- Stalled ticks:
  - Stimulus: in RUN at 0 with `dec_i` = 0 for 5 cycles.
  - Response: `will_underflow_o` stays high, `value_o` stays 0, no expiry until `dec_i` is asserted.

Source files
------------

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot or auto-reload operation.
// Flags the zero count one tick ahead and pulses expired_o after each underflow tick.
module down_timer #(
  parameter int Limit = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic [$clog2(Limit)-1:0] load_value_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     dec_i,
  input  logic                     auto_reload_i,
  output logic [$clog2(Limit)-1:0] value_o,
  output logic                     busy_o,
  output logic                     will_underflow_o,
  output logic                     expired_o
);

  localparam int Width = $clog2(Limit);
  localparam logic [Width:0]   LimitExt = (Width + 1)'(Limit);
  localparam logic [Width-1:0] MaxValue = Width'(Limit - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] value_q, value_d;
  logic [Width-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;
  logic [Width-1:0] load_clamped;

  // Values beyond the count range exist only when Limit is not a power of two.
  assign load_clamped = ({1'b0, load_value_i} >= LimitExt) ? MaxValue : load_value_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      value_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  // Only the highest-priority asserted control acts: load > stop > start > dec.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (load_i) begin
      value_d  = load_clamped;
      reload_d = load_clamped;
      state_d  = IDLE;
    end else if (stop_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      state_d = RUN;
    end else if (dec_i && (state_q == RUN)) begin
      if (value_q != '0) begin
        value_d = value_q - 1'b1;
      end else begin
        expired_d = 1'b1;
        if (auto_reload_i) begin
          value_d = reload_q;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  assign value_o          = value_q;
  assign busy_o           = (state_q == RUN);
  assign will_underflow_o = (state_q == RUN) && (value_q == '0);
  assign expired_o        = expired_q;

endmodule
